// File: rtl/ht1080z_cas_pkg.sv
// Shared definitions for the HT-1080Z cassette playback block:
// FSM state encoding and default tape timing constants.
package ht1080z_cas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CELL  = 2'd2,
        ST_DONE  = 2'd3
    } cas_state_t;

    localparam int DEF_CLK_HZ   = 42_000_000;
    localparam int DEF_PULSE_US = 128;
    localparam int DEF_CELL_US  = 2000;

endpackage

// File: rtl/cas_us_tick.sv
// Microsecond prescaler: one-cycle tick every DIV enabled clocks.
// The count holds while en is low, so a paused tape resumes mid-microsecond.
module cas_us_tick #(
    parameter int DIV = 42
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/cas_player.sv
// Cassette image player: streams bytes from a buffer as 500-baud pulse cells,
// clock pulse at cell start plus a mid-cell pulse for each 1 bit, MSB first.
module cas_player
    import ht1080z_cas_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int PULSE_US = DEF_PULSE_US,
    parameter int CELL_US  = DEF_CELL_US
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        motor,
    input  logic        rewind,
    input  logic [15:0] tape_len,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        cas_out,
    output logic        playing,
    output logic        eot,
    output logic [15:0] tape_pos
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = $clog2(CELL_US);
    localparam logic [CW-1:0] CELL_LAST = CW'(CELL_US - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_US);
    localparam logic [CW-1:0] HALF      = CW'(CELL_US / 2);
    localparam logic [CW-1:0] HALF_END  = CW'(CELL_US / 2 + PULSE_US);

    cas_state_t    state;
    logic [15:0]   len_q;
    logic [7:0]    shift_q;
    logic [7:0]    next_q;
    logic          next_full;
    logic          wait_next;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cell_us;

    logic          us_tick;
    logic          ack;
    logic          have_next;
    logic          more_bytes;
    logic          restart;
    logic [16:0]   pos_inc;
    logic [7:0]    next_byte;

    // Acks are only meaningful against our own outstanding request; late
    // strobes after reset or rewind fall away here.
    assign ack        = mem_ack && mem_rd;
    assign pos_inc    = {1'b0, tape_pos} + 17'd1;
    assign more_bytes = pos_inc < {1'b0, len_q};
    assign have_next  = next_full || ack;
    assign next_byte  = next_full ? next_q : mem_data;

    // A byte that starts a cell after a gap re-phases the prescaler, so its
    // first clock pulse begins the cycle after the ack and lasts full width.
    assign restart = !rewind &&
                     ((state == ST_FETCH && ack) ||
                      (state == ST_CELL && wait_next && motor && have_next));

    cas_us_tick #(
        .DIV (DIV)
    ) u_us_tick (
        .clk_sys (clk_sys),
        .reset   (reset || restart),
        .en      (motor),
        .tick    (us_tick)
    );

    assign playing = motor && (state == ST_FETCH || state == ST_CELL);

    assign cas_out = motor && (state == ST_CELL) && !wait_next &&
                     ((cell_us < PULSE_END) ||
                      (shift_q[bit_idx] && cell_us >= HALF && cell_us < HALF_END));

    always_ff @(posedge clk_sys) begin
        if (reset || rewind) begin
            state     <= ST_IDLE;
            tape_pos  <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            next_q    <= '0;
            next_full <= 1'b0;
            wait_next <= 1'b0;
            bit_idx   <= '0;
            cell_us   <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            eot       <= 1'b0;
        end else begin
            if (ack) begin
                mem_rd <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (motor && tape_pos < tape_len) begin
                        len_q    <= tape_len;
                        mem_rd   <= 1'b1;
                        mem_addr <= tape_pos;
                        state    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (ack) begin
                        shift_q <= mem_data;
                        bit_idx <= 3'd7;
                        cell_us <= '0;
                        state   <= ST_CELL;
                    end
                end

                ST_CELL: begin
                    if (ack) begin
                        next_q    <= mem_data;
                        next_full <= 1'b1;
                    end

                    if (wait_next) begin
                        if (restart) begin
                            tape_pos  <= pos_inc[15:0];
                            shift_q   <= next_byte;
                            bit_idx   <= 3'd7;
                            cell_us   <= '0;
                            next_full <= 1'b0;
                            wait_next <= 1'b0;
                        end
                    end else if (us_tick) begin
                        if (cell_us != CELL_LAST) begin
                            cell_us <= cell_us + CW'(1);
                        end else if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            cell_us <= '0;
                            // Entering the last cell: fetch the following byte early.
                            if (bit_idx == 3'd1 && more_bytes) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= pos_inc[15:0];
                            end
                        end else if (!more_bytes) begin
                            tape_pos <= pos_inc[15:0];
                            eot      <= 1'b1;
                            state    <= ST_DONE;
                        end else if (have_next) begin
                            tape_pos  <= pos_inc[15:0];
                            shift_q   <= next_byte;
                            bit_idx   <= 3'd7;
                            cell_us   <= '0;
                            next_full <= 1'b0;
                        end else begin
                            wait_next <= 1'b1;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cas_player.sv
// Scoreboard bench for cas_player at a scaled clock (2 cycles per us,
// 4 us pulses, 20 us cells) so whole bytes play in a few hundred cycles.
`timescale 1ns/1ps
module tb_cas_player;

    localparam int CLK_HZ   = 2_000_000;
    localparam int PULSE_US = 4;
    localparam int CELL_US  = 20;
    localparam int CPU      = CLK_HZ / 1_000_000;
    localparam int PW       = PULSE_US * CPU;
    localparam int HALF_C   = (CELL_US / 2) * CPU;
    localparam int CELL_C   = CELL_US * CPU;

    typedef struct {
        bit from_ack;
        int gap;
        int width;
    } pulse_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        motor;
    logic        rewind;
    logic [15:0] tape_len;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        cas_out;
    logic        playing;
    logic        eot;
    logic [15:0] tape_pos;

    logic        resp_ack;
    logic [7:0]  resp_data;
    logic        man_ack;
    logic [7:0]  man_data;
    bit          resp_en;
    int          rd_cnt;
    logic [7:0]  img [0:3];
    int          dly [0:3];

    pulse_t      exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    logic        mon_prev;
    int          mon_start;
    int          mon_last;
    int          mon_ack;
    pulse_t      mon_e;

    assign mem_ack  = resp_ack | man_ack;
    assign mem_data = man_ack ? man_data : resp_data;

    cas_player #(
        .CLK_HZ   (CLK_HZ),
        .PULSE_US (PULSE_US),
        .CELL_US  (CELL_US)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .motor    (motor),
        .rewind   (rewind),
        .tape_len (tape_len),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .cas_out  (cas_out),
        .playing  (playing),
        .eot      (eot),
        .tape_pos (tape_pos)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic pulse_t mk(input bit fa, input int gap, input int width);
        pulse_t p;
        p.from_ack = fa;
        p.gap      = gap;
        p.width    = width;
        return p;
    endfunction

    // Expected pulse train of one byte; returns the gap to the next clock pulse.
    task automatic push_byte(input logic [7:0] b, input bit from_ack, input int first_gap,
                             output int next_gap);
        int gap;
        bit fa;
        gap = first_gap;
        fa  = from_ack;
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(mk(fa, gap, PW));
            fa = 1'b0;
            if (b[i]) begin
                exp_q.push_back(mk(1'b0, HALF_C, PW));
                gap = CELL_C - HALF_C;
            end else begin
                gap = CELL_C;
            end
        end
        next_gap = gap;
    endtask

    task automatic do_rewind(input string nm);
        motor  = 1'b0;
        step();
        rewind = 1'b1;
        step();
        rewind = 1'b0;
        check({nm, "_pos"}, tape_pos, 0);
        check({nm, "_eot"}, eot, 0);
    endtask

    task automatic wait_ack(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (mem_ack) begin
                t = cyc;
                break;
            end
        end
        check("ack_seen", (t >= 0) ? 1 : 0, 1);
    endtask

    task automatic wait_eot(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (eot) break;
        end
        check({nm, "_eot"}, eot, 1);
    endtask

    // Memory model: acks dly[addr] cycles after mem_rd rises.
    initial begin
        resp_ack  = 1'b0;
        resp_data = 8'h00;
        rd_cnt    = 0;
        forever begin
            step();
            if (!resp_en) begin
                resp_ack = 1'b0;
                rd_cnt   = 0;
            end else if (resp_ack) begin
                resp_ack = 1'b0;
                rd_cnt   = 0;
            end else if (mem_rd) begin
                rd_cnt++;
                if (rd_cnt > dly[mem_addr[1:0]]) begin
                    resp_ack  = 1'b1;
                    resp_data = img[mem_addr[1:0]];
                end
            end else begin
                rd_cnt = 0;
            end
        end
    end

    // Pulse monitor: each completed cas_out pulse is checked against the queue.
    initial begin
        mon_prev  = 1'b0;
        mon_start = 0;
        mon_last  = 0;
        mon_ack   = 0;
        forever begin
            @(negedge clk_sys);
            if (mem_ack) mon_ack = cyc;
            if (cas_out && !mon_prev) mon_start = cyc;
            if (!cas_out && mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got pulse at cycle %0d width %0d, expected none",
                             mon_start, cyc - mon_start);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_gap", mon_start - (mon_e.from_ack ? mon_ack : mon_last), mon_e.gap);
                    check("pulse_width", cyc - mon_start, mon_e.width);
                end
                mon_last = mon_start;
            end
            mon_prev = cas_out;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int g;
        int t;
        bit seen_rd;
        bit seen_cas;
        bit seen_play;

        reset    = 1'b1;
        motor    = 1'b0;
        rewind   = 1'b0;
        tape_len = 16'd0;
        man_ack  = 1'b0;
        man_data = 8'h00;
        resp_en  = 1'b1;
        img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
        dly[0] = 0;     dly[1] = 0;     dly[2] = 0;     dly[3] = 0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_cas_out", cas_out, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_playing", playing, 0);
        check("rst_eot", eot, 0);
        check("rst_tape_pos", tape_pos, 0);

        // One byte 0xA5, ack three cycles after the request.
        step();
        img[0] = 8'hA5; dly[0] = 3; tape_len = 16'd1;
        push_byte(8'hA5, 1'b1, 1, g);
        motor = 1'b1;
        wait_ack(50, a);
        check("s1_fetch_addr", mem_addr, 0);
        wait_eot("s1", 2000);
        check("s1_tape_pos", tape_pos, 1);
        check("s1_playing", playing, 0);
        check("s1_pulses_left", exp_q.size(), 0);
        do_rewind("s1_rw");

        // Two bytes, immediate acks, seamless hand-over via prefetch.
        img[0] = 8'h00; img[1] = 8'hFF; dly[0] = 0; dly[1] = 0; tape_len = 16'd2;
        push_byte(8'h00, 1'b1, 1, g);
        push_byte(8'hFF, 1'b0, g, g);
        motor = 1'b1;
        wait_ack(50, a);
        t = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_sys);
            if (mem_rd && mem_addr == 16'd1) begin
                t = cyc;
                break;
            end
        end
        check("s2_prefetch_cycle", t, a + 1 + 7 * CELL_C);
        wait_eot("s2", 2000);
        check("s2_tape_pos", tape_pos, 2);
        check("s2_pulses_left", exp_q.size(), 0);
        do_rewind("s2_rw");

        // Slow prefetch: line idles after the last cell until the ack arrives.
        img[0] = 8'h01; img[1] = 8'h80; dly[0] = 0; dly[1] = 150; tape_len = 16'd2;
        push_byte(8'h01, 1'b1, 1, g);
        push_byte(8'h80, 1'b1, 1, g);
        motor = 1'b1;
        wait_eot("s3", 2000);
        check("s3_tape_pos", tape_pos, 2);
        check("s3_pulses_left", exp_q.size(), 0);
        do_rewind("s3_rw");

        // Motor paused 20 cycles in the first cell: later pulses slip by 20.
        img[0] = 8'h80; dly[0] = 0; tape_len = 16'd1;
        exp_q.push_back(mk(1'b1, 1, PW));
        exp_q.push_back(mk(1'b0, HALF_C + 20, PW));
        for (int i = 6; i >= 0; i--) begin
            exp_q.push_back(mk(1'b0, (i == 6) ? (CELL_C - HALF_C) : CELL_C, PW));
        end
        motor = 1'b1;
        wait_ack(50, a);
        repeat (5) step();
        check("s4_playing_on", playing, 1);
        repeat (7) step();
        motor = 1'b0;
        repeat (8) step();
        check("s4_playing_off", playing, 0);
        check("s4_tape_pos_frozen", tape_pos, 0);
        repeat (12) step();
        motor = 1'b1;
        wait_eot("s4", 2000);
        check("s4_tape_pos", tape_pos, 1);
        check("s4_pulses_left", exp_q.size(), 0);

        // Rewind out of DONE with motor on, then rewind colliding with an ack.
        resp_en = 1'b0;
        repeat (3) step();
        rewind = 1'b1;
        step();
        rewind = 1'b0;
        check("s5_done_rw_eot", eot, 0);
        check("s5_done_rw_pos", tape_pos, 0);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (mem_rd) begin
                t = cyc;
                break;
            end
        end
        check("s5_refetch", (t >= 0) ? 1 : 0, 1);
        step();
        man_data = 8'hFF;
        man_ack  = 1'b1;
        rewind   = 1'b1;
        step();
        man_ack  = 1'b0;
        rewind   = 1'b0;
        motor    = 1'b0;
        check("s5_mem_rd", mem_rd, 0);
        check("s5_playing", playing, 0);
        check("s5_tape_pos", tape_pos, 0);
        check("s5_eot", eot, 0);
        repeat (100) step();
        check("s5_pulses_left", exp_q.size(), 0);

        // Reset during an outstanding read, then a stray ack.
        motor = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (mem_rd) break;
        end
        step();
        reset = 1'b1;
        motor = 1'b0;
        step();
        reset = 1'b0;
        check("s6_rst_mem_rd", mem_rd, 0);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        repeat (5) step();
        check("s6_late_ack_pos", tape_pos, 0);
        check("s6_late_ack_rd", mem_rd, 0);
        resp_en = 1'b1;

        // Empty tape: nothing may happen while the motor runs.
        tape_len  = 16'd0;
        motor     = 1'b1;
        seen_rd   = 1'b0;
        seen_cas  = 1'b0;
        seen_play = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            seen_rd   |= mem_rd;
            seen_cas  |= cas_out;
            seen_play |= playing;
        end
        check("s7_mem_rd", seen_rd, 0);
        check("s7_cas_out", seen_cas, 0);
        check("s7_playing", seen_play, 0);
        motor = 1'b0;
        step();
        check("final_pulses_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
